// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mips_cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } md_state_t;

    // Magnitude of a word when treated as signed; passes the raw value otherwise.
    function automatic logic [XLEN-1:0] md_abs(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/mips_cpu_multdiv_ctrl_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface mips_cpu_multdiv_ctrl_if;
    import mips_cpu_pkg::*;

    logic            start;
    md_op_t          op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mips_cpu_multdiv_step.sv
// One radix-2 iteration: right shift-add multiply or left restoring shift-subtract divide.
module mips_cpu_multdiv_step
    import mips_cpu_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);

    logic [XLEN:0]   sum;
    logic [XLEN+1:0] diff;

    always_comb begin
        acc_next = acc;
        q_bit    = 1'b0;
        sum      = '0;
        diff     = '0;
        if (is_div) begin
            // Remainder after the shift can be XLEN+1 bits wide; borrow lands in the top bit.
            diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, opnd};
            if (!diff[XLEN+1]) begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                q_bit    = 1'b1;
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : (XLEN+1)'(0));
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_multdiv_ctrl.sv
// Sequencer for MULT/MULTU/DIV/DIVU with sign fix-up and the architectural HI/LO registers.
module mips_cpu_multdiv_ctrl
    import mips_cpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    mips_cpu_multdiv_ctrl_if.slave  bus
);

    md_state_t             state, state_d;
    md_op_t                op_q;
    logic [2*XLEN-1:0]     acc;
    logic [XLEN-1:0]       opnd;
    logic [MD_CNT_W-1:0]   cnt;
    logic                  neg_q, neg_r, div0;
    logic [XLEN-1:0]       hi_q, lo_q;
    logic                  busy_q, done_q;
    logic                  busy_d, done_d;

    logic                  is_div, is_signed, div_zero;
    logic [2*XLEN-1:0]     step_acc;
    logic                  step_q;
    logic [2*XLEN-1:0]     prod_neg;

    assign is_div    = (op_q == DIV)  || (op_q == DIVU);
    assign is_signed = (op_q == MULT) || (op_q == DIV);
    assign div_zero  = is_div && (opnd == '0);
    assign prod_neg  = (2*XLEN)'(-acc);

    mips_cpu_multdiv_step u_step (
        .acc      (acc),
        .opnd     (opnd),
        .is_div   (is_div),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state plus registered busy/done; busy drops in the DONE cycle.
    always_comb begin
        state_d = state;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_d = INIT;
            INIT:    state_d = div_zero ? FIXUP : ITER;
            ITER:    if (cnt == MD_CNT_W'(1)) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == INIT) || (state_d == ITER) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Operands ride in acc/opnd raw from IDLE; INIT turns them into magnitudes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= MULT;
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mthi) hi_q <= bus.wdata;
                    if (bus.mtlo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q <= bus.op;
                        acc  <= {{XLEN{1'b0}}, bus.a};
                        opnd <= bus.b;
                    end
                end
                INIT: begin
                    neg_q <= is_signed && (acc[XLEN-1] ^ opnd[XLEN-1]);
                    neg_r <= is_signed && acc[XLEN-1];
                    div0  <= div_zero;
                    cnt   <= MD_CNT_W'(MD_ITER);
                    opnd  <= md_abs(opnd, is_signed);
                    if (div_zero) acc <= {acc[XLEN-1:0], {XLEN{1'b1}}};
                    else          acc <= {{XLEN{1'b0}}, md_abs(acc[XLEN-1:0], is_signed)};
                end
                ITER: begin
                    acc <= {step_acc[2*XLEN-1:1], step_acc[0] | step_q};
                    cnt <= cnt - MD_CNT_W'(1);
                end
                FIXUP: begin
                    if (div0) begin
                        hi_q <= acc[2*XLEN-1:XLEN];
                        lo_q <= acc[XLEN-1:0];
                    end else if (!is_div) begin
                        hi_q <= neg_q ? prod_neg[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
                        lo_q <= neg_q ? prod_neg[XLEN-1:0]      : acc[XLEN-1:0];
                    end else begin
                        hi_q <= neg_r ? XLEN'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
                        lo_q <= neg_q ? XLEN'(-acc[XLEN-1:0])      : acc[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_multdiv_ctrl.sv
// Bench for mips_cpu_multdiv_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_mips_cpu_multdiv_ctrl;
    import mips_cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_cpu_multdiv_ctrl_if bus ();

    mips_cpu_multdiv_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] pv, qv, rv;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MULT: begin
                p = sa * sb; pv = p;
                return pv;
            end
            MULTU: begin
                pv = {32'b0, a} * {32'b0, b};
                return pv;
            end
            DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb;
                qv = q; rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = a / b; ur = a % b;
                return {ur, uq};
            end
        endcase
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.op = MULT; bus.a = '0; bus.b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    endtask

    task automatic move(input logic en_hi, input logic en_lo, input logic [31:0] data);
        @(negedge clk);
        bus.mthi = en_hi; bus.mtlo = en_lo; bus.wdata = data;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        if (en_hi) m_hi = data;
        if (en_lo) m_lo = data;
        check("mv_hi", {32'b0, bus.hi}, {32'b0, m_hi});
        check("mv_lo", {32'b0, bus.lo}, {32'b0, m_lo});
    endtask

    // Issue one op; optionally combine with mthi, or poke start+moves mid-operation at cycle inject_at.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input logic mv_hi, input logic [31:0] mv_data);
        logic [63:0] exp;
        int lat, exp_lat;
        exp = model(op, a, b);
        exp_lat = ((op == DIV || op == DIVU) && b == 32'd0) ? 2 : 34;
        lat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        bus.mthi = mv_hi; bus.wdata = mv_data;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0;
        if (mv_hi) m_hi = mv_data;
        for (int n = 1; n <= 40; n++) begin
            if (n == inject_at) begin
                bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd50; bus.b = 32'd5;
                bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'd9;
            end
            @(posedge clk); #1;
            bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            if (bus.done) begin lat = n; break; end
            if (n == 1) begin
                check("busy", {63'b0, bus.busy}, 64'd1);
                check("hi_early", {32'b0, bus.hi}, {32'b0, m_hi});
            end
            if (n == 20) begin
                check("hi_hold", {32'b0, bus.hi}, {32'b0, m_hi});
                check("lo_hold", {32'b0, bus.lo}, {32'b0, m_lo});
            end
        end
        check($sformatf("latency op%0d", op), 64'(lat), 64'(exp_lat));
        if (lat > 0) begin
            check("busy_at_done", {63'b0, bus.busy}, 64'd0);
            check($sformatf("hilo op%0d a=%h b=%h", op, a, b), {bus.hi, bus.lo}, exp);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
            @(posedge clk); #1;
            check("done_pulse", {63'b0, bus.done}, 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 20));
            1:       return 32'h8000_0000;
            2:       return 32'(-$urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb;
        md_op_t rop;
        idle_inputs();
        #12;
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_hi", {32'b0, bus.hi}, 64'd0);
        check("rst_lo", {32'b0, bus.lo}, 64'd0);
        rst_n = 1'b1;

        run_op(MULT,  32'hFFFF_FFFD, 32'd7,         0, 1'b0, '0);
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, '0);
        run_op(DIV,   32'hFFFF_FFF9, 32'd2,         0, 1'b0, '0);
        run_op(DIVU,  32'd100,       32'd7,         0, 1'b0, '0);
        run_op(DIVU,  32'd5,         32'd0,         0, 1'b0, '0);
        run_op(DIV,   32'hFFFF_FFF9, 32'd0,         0, 1'b0, '0);
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, '0);
        run_op(MULT,  32'd3,         32'd4,        10, 1'b0, '0);

        move(1'b1, 1'b0, 32'h1234_5678);
        move(1'b0, 1'b1, 32'hCAFE_F00D);
        move(1'b1, 1'b1, 32'h0BAD_BEEF);
        run_op(DIV, 32'd1000, 32'hFFFF_FFFD, 0, 1'b1, 32'h7777_0001);

        // Abort a DIVU partway through with reset.
        move(1'b1, 1'b1, 32'hA5A5_A5A5);
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd1000; bus.b = 32'd7;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_hi", {32'b0, bus.hi}, 64'd0);
        check("abort_lo", {32'b0, bus.lo}, 64'd0);
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_done", {63'b0, bus.done}, 64'd0);
        m_hi = '0; m_lo = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_quiet", {62'b0, bus.busy, bus.done}, 64'd0);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        run_op(MULTU, 32'd2, 32'd3, 0, 1'b0, '0);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (bus.done) check("stale_done", 64'd1, 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            rop = md_op_t'($urandom_range(0, 3));
            ra  = rand_val();
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_val();
            run_op(rop, ra, rb, 0, 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
